// File: rtl/riscv_pkg.sv
// Shared front-end types: return address stack sizing and its checkpoint record.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RAS_DEPTH = 8;
  localparam int unsigned RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned RAS_CNT_W = $clog2(RAS_DEPTH + 1);

  typedef struct packed {
    logic [RAS_PTR_W-1:0] tos;
    logic [RAS_CNT_W-1:0] count;
    logic [XLEN-1:0]      top;
  } ras_ckpt_t;

endpackage

// File: rtl/ras_predictor.sv
// Return address stack: circular storage, same-cycle return prediction and a
// per-instruction checkpoint for speculative repair.
module ras_predictor
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = RAS_DEPTH,
  parameter int unsigned XLEN  = riscv_pkg::XLEN
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall,
  input  logic            i_is_call,
  input  logic            i_is_return,
  input  logic            i_is_coroutine,
  input  logic [XLEN-1:0] i_link_addr,
  input  logic            i_clear,
  input  logic            i_restore_valid,
  input  ras_ckpt_t       i_restore_ckpt,
  output logic            o_predict_valid,
  output logic [XLEN-1:0] o_predict_target,
  output ras_ckpt_t       o_ckpt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(DEPTH);

  logic [XLEN-1:0]  stack [DEPTH];
  logic [PTR_W-1:0] tos;
  logic [CNT_W-1:0] count;

  logic             empty;
  logic             coroutine;
  logic             do_push;
  logic             do_swap;
  logic             do_pop;
  logic [PTR_W-1:0] tos_inc;
  logic [PTR_W-1:0] tos_dec;

  always_comb begin
    empty     = (count == '0);
    // C.JALR x5 raises both call and return; it must swap, not push.
    coroutine = i_is_coroutine | (i_is_call & i_is_return);
    do_push   = (i_is_call & ~coroutine) | (coroutine & empty);
    do_swap   = coroutine & ~empty;
    do_pop    = i_is_return & ~coroutine & ~empty;
    tos_inc   = tos + PtrOne;
    tos_dec   = tos - PtrOne;
  end

  always_comb begin
    o_predict_valid  = (i_is_return | i_is_coroutine) & ~empty;
    o_predict_target = o_predict_valid ? stack[tos] : '0;
    o_ckpt.tos       = tos;
    o_ckpt.count     = count;
    o_ckpt.top       = stack[tos];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tos   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else if (i_clear) begin
      count <= '0;
    end else if (i_restore_valid) begin
      tos                        <= i_restore_ckpt.tos;
      count                      <= i_restore_ckpt.count;
      stack[i_restore_ckpt.tos]  <= i_restore_ckpt.top;
    end else if (!i_stall) begin
      if (do_push) begin
        tos            <= tos_inc;
        stack[tos_inc] <= i_link_addr;
        if (count != CntFull) begin
          count <= count + CntOne;
        end
      end else if (do_swap) begin
        stack[tos] <= i_link_addr;
      end else if (do_pop) begin
        tos   <= tos_dec;
        count <= count - CntOne;
      end
    end
  end

endmodule

// File: tb/tb_ras_predictor.sv
// Bench for ras_predictor: directed scenarios with fixed expectations, then
// random traffic compared against an array-based return stack model.
module tb_ras_predictor;
  import riscv_pkg::*;

  localparam int D = RAS_DEPTH;

  logic            clk;
  logic            rst_n;
  logic            stall;
  logic            is_call;
  logic            is_return;
  logic            is_coroutine;
  logic [XLEN-1:0] link_addr;
  logic            clear;
  logic            restore_valid;
  ras_ckpt_t       restore_ckpt;
  logic            predict_valid;
  logic [XLEN-1:0] predict_target;
  ras_ckpt_t       ckpt;

  int checks;
  int errors;

  // Reference model: plain circular array with modular integer indices.
  logic [XLEN-1:0] m_stack [D];
  int              m_tos;
  int              m_cnt;
  ras_ckpt_t       saved;

  ras_predictor #(.DEPTH(D), .XLEN(XLEN)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_stall         (stall),
    .i_is_call       (is_call),
    .i_is_return     (is_return),
    .i_is_coroutine  (is_coroutine),
    .i_link_addr     (link_addr),
    .i_clear         (clear),
    .i_restore_valid (restore_valid),
    .i_restore_ckpt  (restore_ckpt),
    .o_predict_valid (predict_valid),
    .o_predict_target(predict_target),
    .o_ckpt          (ckpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tos = 0;
    m_cnt = 0;
    for (int i = 0; i < D; i++) m_stack[i] = '0;
  endtask

  task automatic model_update();
    bit cor;
    cor = is_coroutine || (is_call && is_return);
    if (clear) begin
      m_cnt = 0;
    end else if (restore_valid) begin
      m_tos          = int'(restore_ckpt.tos);
      m_cnt          = int'(restore_ckpt.count);
      m_stack[m_tos] = restore_ckpt.top;
    end else if (!stall) begin
      if ((cor && m_cnt == 0) || (is_call && !cor)) begin
        m_tos          = (m_tos + 1) % D;
        m_stack[m_tos] = link_addr;
        if (m_cnt < D) m_cnt++;
      end else if (cor) begin
        m_stack[m_tos] = link_addr;
      end else if (is_return && m_cnt > 0) begin
        m_tos = (m_tos + D - 1) % D;
        m_cnt--;
      end
    end
  endtask

  task automatic idle_inputs();
    stall         = 1'b0;
    is_call       = 1'b0;
    is_return     = 1'b0;
    is_coroutine  = 1'b0;
    link_addr     = '0;
    clear         = 1'b0;
    restore_valid = 1'b0;
    restore_ckpt  = '0;
  endtask

  // Compare against the model before the edge, clock, then advance the model.
  task automatic tick();
    logic            exp_v;
    logic [XLEN-1:0] exp_t;
    #1;
    exp_v = (is_return || is_coroutine) && (m_cnt != 0);
    exp_t = exp_v ? m_stack[m_tos] : '0;
    check_val("pred_valid", 64'(predict_valid), 64'(exp_v));
    check_val("pred_target", 64'(predict_target), 64'(exp_t));
    check_val("ckpt_tos", 64'(ckpt.tos), 64'(m_tos));
    check_val("ckpt_count", 64'(ckpt.count), 64'(m_cnt));
    check_val("ckpt_top", 64'(ckpt.top), 64'(m_stack[m_tos]));
    @(posedge clk);
    model_update();
    #1;
    idle_inputs();
  endtask

  task automatic push(input logic [XLEN-1:0] a);
    is_call   = 1'b1;
    link_addr = a;
    tick();
  endtask

  task automatic ret_expect(input string tag, input logic v, input logic [XLEN-1:0] t);
    is_return = 1'b1;
    #1;
    check_val({tag, "_v"}, 64'(predict_valid), 64'(v));
    check_val({tag, "_t"}, 64'(predict_target), 64'(t));
    tick();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    is_return = 1'b1;
    check_val("rst_pred_v", 64'(predict_valid), 64'd0);
    check_val("rst_count", 64'(ckpt.count), 64'd0);
    check_val("rst_tos", 64'(ckpt.tos), 64'd0);
    check_val("rst_top", 64'(ckpt.top), 64'd0);
    rst_n = 1'b1;
    is_return = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    model_reset();
    saved = '0;
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: return on an empty stack
    ret_expect("empty_ret", 1'b0, '0);
    check_val("empty_count", 64'(ckpt.count), 64'd0);

    // 2: simple LIFO
    push(32'h100);
    push(32'h200);
    push(32'h300);
    ret_expect("lifo0", 1'b1, 32'h300);
    ret_expect("lifo1", 1'b1, 32'h200);
    ret_expect("lifo2", 1'b1, 32'h100);
    ret_expect("lifo3", 1'b0, '0);

    // 3: overflow wraps and drops the two oldest
    for (int i = 1; i <= 10; i++) push(XLEN'(i * 16));
    check_val("ovf_count", 64'(ckpt.count), 64'(D));
    for (int i = 10; i >= 3; i--) ret_expect("ovf", 1'b1, XLEN'(i * 16));
    ret_expect("ovf_empty", 1'b0, '0);

    // 4: coroutine swap via call+return
    push(32'h100);
    is_call = 1'b1; is_return = 1'b1; link_addr = 32'h400;
    #1;
    check_val("cor_pred_t", 64'(predict_target), 64'h100);
    tick();
    check_val("cor_count", 64'(ckpt.count), 64'd1);
    ret_expect("cor_ret", 1'b1, 32'h400);
    ret_expect("cor_empty", 1'b0, '0);

    // 5: checkpoint repair
    pulse_reset();
    push(32'h100);
    push(32'h200);
    is_return = 1'b1;
    #1;
    saved = ckpt;
    check_val("ck_tos", 64'(saved.tos), 64'd2);
    check_val("ck_count", 64'(saved.count), 64'd2);
    check_val("ck_top", 64'(saved.top), 64'h200);
    tick();
    push(32'h500);
    restore_valid = 1'b1; restore_ckpt = saved; is_call = 1'b1; link_addr = 32'h999;
    tick();
    ret_expect("rep0", 1'b1, 32'h200);
    ret_expect("rep1", 1'b1, 32'h100);

    // 6: stall, clear, async reset
    push(32'h700);
    is_return = 1'b1; stall = 1'b1;
    #1;
    check_val("stall_t", 64'(predict_target), 64'h700);
    tick();
    check_val("stall_count", 64'(ckpt.count), 64'd1);
    clear = 1'b1; is_call = 1'b1; link_addr = 32'h800;
    tick();
    check_val("clear_count", 64'(ckpt.count), 64'd0);
    push(32'h900);
    #2;
    pulse_reset();
    ret_expect("post_rst", 1'b0, '0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int r;
      r            = int'($urandom_range(0, 99));
      is_call      = ($urandom_range(0, 99) < 45);
      is_return    = ($urandom_range(0, 99) < 40);
      is_coroutine = ($urandom_range(0, 99) < 10);
      stall        = ($urandom_range(0, 99) < 10);
      clear        = (r < 3);
      link_addr    = $urandom;
      if (r >= 3 && r < 9) begin
        restore_valid = 1'b1;
        restore_ckpt  = saved;
      end
      if ($urandom_range(0, 99) < 10) begin
        saved.tos   = RAS_PTR_W'(m_tos);
        saved.count = RAS_CNT_W'(m_cnt);
        saved.top   = m_stack[m_tos];
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
